avalon_mem_bank_responder: RTL and testbench

Avalon-MM local-memory responder: the FIU/memory-controller end of one avalon_mem_if bank, backed by on-chip RAM.
Accepts burst reads and writes from an AFU-side master (directly or through the timing/clock-crossing shims), stores data, and returns read bursts with a fixed configurable latency.
Used as a simulation/emulation stand-in for a DDR bank, and as the loopback target for shim verification.

---
 rtl/avalon_mem_responder_pkg.sv | 15 +
 rtl/avalon_mem_responder_ram.sv | 40 ++++
 rtl/avalon_mem_bank_responder.sv | 181 ++++++++++++++++++
 tb/tb_avalon_mem_bank_responder.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/avalon_mem_responder_pkg.sv
// Shared types and helpers for the Avalon-MM memory bank responder.
package avalon_mem_responder_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WR_BURST = 2'd1,
    RD_BURST = 2'd2
  } t_rsp_state;

  // Reduce a word address to its backing-RAM index; bursts wrap modulo the RAM depth.
  function automatic logic [31:0] wrap_index(input logic [31:0] addr, input int depth_log2);
    return addr & ((32'd1 << depth_log2) - 32'd1);
  endfunction

endpackage

// File: rtl/avalon_mem_responder_ram.sv
// Simple dual-port backing RAM: one byte-enabled write port, one read port
// with a single registered output stage.
module avalon_mem_responder_ram
  import avalon_mem_responder_pkg::*;
#(
  parameter int DATA_WIDTH     = 512,
  parameter int MEM_DEPTH_LOG2 = 10
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      wr_en,
  input  logic [MEM_DEPTH_LOG2-1:0] wr_idx,
  input  logic [DATA_WIDTH-1:0]     wr_data,
  input  logic [DATA_WIDTH/8-1:0]   wr_be,
  input  logic                      rd_en,
  input  logic [MEM_DEPTH_LOG2-1:0] rd_idx,
  output logic [DATA_WIDTH-1:0]     rd_data
);

  localparam int DEPTH  = 2 ** MEM_DEPTH_LOG2;
  localparam int NBYTES = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Byte-granular write; contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < NBYTES; b++) begin
        if (wr_be[b]) mem[wr_idx][b*8 +: 8] <= wr_data[b*8 +: 8];
      end
    end
  end

  // Registered read; the output register clears so readdata is 0 out of reset.
  always_ff @(posedge clk) begin
    if (reset) rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_idx];
  end

endmodule

// File: rtl/avalon_mem_bank_responder.sv
// Avalon-MM responder for one memory bank, backed by on-chip RAM.
// Optional build macro AVALON_MEM_RESPONDER_RANDOM_WAIT_EN adds LFSR-driven
// pseudo-random waitrequest stalls in IDLE/WR_BURST.
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | ready for a new command; single-beat writes commit here
// WR_BURST | collecting remaining write beats at the latched address
// RD_BURST | issuing one RAM read per cycle, waitrequest held high
module avalon_mem_bank_responder
  import avalon_mem_responder_pkg::*;
#(
  parameter int ADDR_WIDTH      = 27,
  parameter int DATA_WIDTH      = 512,
  parameter int BURST_CNT_WIDTH = 7,
  parameter int MEM_DEPTH_LOG2  = 10,
  parameter int READ_LATENCY    = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [ADDR_WIDTH-1:0]      address,
  input  logic [BURST_CNT_WIDTH-1:0] burstcount,
  input  logic                       read,
  input  logic                       write,
  input  logic [DATA_WIDTH-1:0]      writedata,
  input  logic [DATA_WIDTH/8-1:0]    byteenable,
  output logic                       waitrequest,
  output logic [DATA_WIDTH-1:0]      readdata,
  output logic                       readdatavalid,
  output logic                       protocol_error
);

  localparam int IDX_W = MEM_DEPTH_LOG2;

  t_rsp_state                 state_q, state_d;
  logic [IDX_W-1:0]           idx_q, idx_d;
  logic [BURST_CNT_WIDTH-1:0] remaining_q, remaining_d;
  logic                       err_q, err_set;
  logic                       stall;
  logic                       ram_we, ram_re;
  logic [IDX_W-1:0]           ram_wr_idx;
  logic [DATA_WIDTH-1:0]      ram_q;
  logic [IDX_W-1:0]           cmd_idx;
  logic [BURST_CNT_WIDTH-1:0] bc_eff;
  logic [READ_LATENCY:0]      vld_q;

  assign cmd_idx = IDX_W'(wrap_index(32'(address), MEM_DEPTH_LOG2));
  // A zero burstcount is a violation but still moves one beat.
  assign bc_eff  = (burstcount == '0) ? BURST_CNT_WIDTH'(1) : burstcount;

`ifdef AVALON_MEM_RESPONDER_RANDOM_WAIT_EN
  logic [15:0] lfsr_q;

  // Free-running maximal-length LFSR used only to inject backpressure.
  always_ff @(posedge clk) begin
    if (reset) lfsr_q <= 16'hACE1;
    else lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end

  assign stall = (state_q != RD_BURST) && (lfsr_q[1:0] == 2'b00);
`else
  assign stall = 1'b0;
`endif

  // Backpressure: always high in reset and while a read burst is issuing.
  always_comb begin
    waitrequest = reset | (state_q == RD_BURST) | stall;
  end

  // Next-state, RAM strobes and violation detection.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    remaining_d = remaining_q;
    ram_we      = 1'b0;
    ram_re      = 1'b0;
    ram_wr_idx  = idx_q;
    err_set     = 1'b0;
    case (state_q)
      IDLE: begin
        if (write && !waitrequest) begin
          ram_we     = 1'b1;
          ram_wr_idx = cmd_idx;
          // A simultaneous read loses to the write and is dropped.
          err_set    = read | (burstcount == '0);
          if (bc_eff != BURST_CNT_WIDTH'(1)) begin
            idx_d       = cmd_idx + IDX_W'(1);
            remaining_d = bc_eff - BURST_CNT_WIDTH'(1);
            state_d     = WR_BURST;
          end
        end else if (read && !waitrequest) begin
          idx_d       = cmd_idx;
          remaining_d = bc_eff;
          err_set     = (burstcount == '0);
          state_d     = RD_BURST;
        end
      end
      WR_BURST: begin
        err_set = read;
        if (write && !waitrequest) begin
          ram_we      = 1'b1;
          idx_d       = idx_q + IDX_W'(1);
          remaining_d = remaining_q - BURST_CNT_WIDTH'(1);
          if (remaining_q == BURST_CNT_WIDTH'(1)) state_d = IDLE;
        end
      end
      RD_BURST: begin
        ram_re      = 1'b1;
        idx_d       = idx_q + IDX_W'(1);
        remaining_d = remaining_q - BURST_CNT_WIDTH'(1);
        if (remaining_q == BURST_CNT_WIDTH'(1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM registers and the sticky violation flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      remaining_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      remaining_q <= remaining_d;
      err_q       <= err_q | err_set;
    end
  end

  assign protocol_error = err_q;

  avalon_mem_responder_ram #(
    .DATA_WIDTH     (DATA_WIDTH),
    .MEM_DEPTH_LOG2 (MEM_DEPTH_LOG2)
  ) u_ram (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (ram_we),
    .wr_idx  (ram_wr_idx),
    .wr_data (writedata),
    .wr_be   (byteenable),
    .rd_en   (ram_re),
    .rd_idx  (idx_q),
    .rd_data (ram_q)
  );

  // Valid shadow of the read pipe; stage 0 lines up with the RAM output register.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q <= '0;
    end else begin
      vld_q[0] <= ram_re;
      for (int k = 1; k <= READ_LATENCY; k++) vld_q[k] <= vld_q[k-1];
    end
  end

  assign readdatavalid = vld_q[READ_LATENCY];

  generate
    if (READ_LATENCY == 0) begin : g_no_pipe
      assign readdata = ram_q;
    end else begin : g_pipe
      logic [DATA_WIDTH-1:0] dpipe_q [READ_LATENCY];

      // Extra read-data stages that model the configured bank latency.
      always_ff @(posedge clk) begin
        if (reset) begin
          for (int k = 0; k < READ_LATENCY; k++) dpipe_q[k] <= '0;
        end else begin
          dpipe_q[0] <= ram_q;
          for (int k = 1; k < READ_LATENCY; k++) dpipe_q[k] <= dpipe_q[k-1];
        end
      end

      assign readdata = dpipe_q[READ_LATENCY-1];
    end
  endgenerate

endmodule

// File: tb/tb_avalon_mem_bank_responder.sv
// Bench for avalon_mem_bank_responder: directed table, corner sequences and
// randomized traffic checked against a word-array memory model.
module tb_avalon_mem_bank_responder;

  localparam int AW = 27, DW = 512, BW = 7, ML = 10, RL = 4, DEPTH = 1024;
  localparam logic [63:0] BE_ALL = '1;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] address;
  logic [BW-1:0] burstcount;
  logic          read, write;
  logic [DW-1:0] writedata;
  logic [63:0]   byteenable;
  logic          waitrequest;
  logic [DW-1:0] readdata;
  logic          readdatavalid;
  logic          protocol_error;

  avalon_mem_bank_responder #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_CNT_WIDTH(BW),
    .MEM_DEPTH_LOG2(ML), .READ_LATENCY(RL)
  ) dut (
    .clk(clk), .reset(reset), .address(address), .burstcount(burstcount),
    .read(read), .write(write), .writedata(writedata), .byteenable(byteenable),
    .waitrequest(waitrequest), .readdata(readdata), .readdatavalid(readdatavalid),
    .protocol_error(protocol_error)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [DW-1:0] rq_data [$];
  int            rq_cyc  [$];
  always @(negedge clk) begin
    if (readdatavalid) begin
      rq_data.push_back(readdata);
      rq_cyc.push_back(cyc);
    end
  end

  int total = 0, bad = 0;
  logic [DW-1:0] model [DEPTH];
  logic [DW-1:0] wbuf  [128];

  typedef struct {
    bit            is_rd;
    int            addr;
    int            bc;
    logic [63:0]   be;
    logic [DW-1:0] data;
    logic [DW-1:0] exp;
  } vec_t;
  vec_t tbl [13];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] rnd512();
    logic [DW-1:0] r;
    for (int w = 0; w < DW / 32; w++) r[w*32 +: 32] = $urandom;
    return r;
  endfunction

  // Wait for the current command/beat to be taken; returns its cycle number.
  task automatic wait_accept(output bit ok, output int t);
    ok = 1'b0;
    t  = 0;
    for (int k = 0; k < 100 && !ok; k++) begin
      @(negedge clk);
      if (!waitrequest) begin
        ok = 1'b1;
        t  = cyc;
      end
    end
    if (ok) begin
      @(posedge clk);
      #1;
    end else begin
      total++;
      bad++;
      $display("FAIL accept_timeout: got waitrequest=1 for 100 cycles want acceptance");
    end
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
    reset = 1'b0;
  endtask

  // Write burst from wbuf; rd_beat selects a beat that also asserts read.
  task automatic do_write(input int addr, input int bc, input logic [63:0] be, input int rd_beat);
    int n, t, idx;
    bit ok;
    n = (bc == 0) ? 1 : bc;
    for (int i = 0; i < n; i++) begin
      address    = (i == 0) ? AW'(addr) : AW'($urandom);
      burstcount = (i == 0) ? BW'(bc) : BW'($urandom);
      write      = 1'b1;
      read       = (i == rd_beat);
      writedata  = wbuf[i];
      byteenable = be;
      wait_accept(ok, t);
      if (!ok) break;
      idx = (addr + i) % DEPTH;
      for (int b = 0; b < DW / 8; b++)
        if (be[b]) model[idx][b*8 +: 8] = wbuf[i][b*8 +: 8];
    end
    write = 1'b0;
    read  = 1'b0;
  endtask

  // Read burst; expected beats come from the table (exp+i) or from the model.
  task automatic do_read(input string name, input int addr, input int bc,
                         input bit use_exp, input logic [DW-1:0] exp);
    int n, t, got;
    bit ok;
    logic [DW-1:0] e;
    n = (bc == 0) ? 1 : bc;
    rq_data.delete();
    rq_cyc.delete();
    address    = AW'(addr);
    burstcount = BW'(bc);
    write      = 1'b0;
    read       = 1'b1;
    wait_accept(ok, t);
    read = 1'b0;
    if (!ok) return;
    for (int j = 0; j < n; j++) begin
      @(negedge clk);
      chk_int({name, "_wait_busy"}, int'(waitrequest), 1);
    end
    @(negedge clk);
    chk_int({name, "_wait_free"}, int'(waitrequest), 0);
    for (int k = 0; k < 60 && rq_data.size() < n; k++) @(negedge clk);
    @(posedge clk);
    chk_int({name, "_beats"}, rq_data.size(), n);
    got = (rq_data.size() < n) ? rq_data.size() : n;
    for (int i = 0; i < got; i++) begin
      e = use_exp ? exp + DW'(i) : model[(addr + i) % DEPTH];
      chk({name, "_data"}, rq_data[i], e);
      chk_int({name, "_lat"}, rq_cyc[i], t + 2 + RL + i);
    end
    repeat (3) @(negedge clk);
    @(posedge clk);
    chk_int({name, "_extra"}, rq_data.size(), n);
    #1;
  endtask

  initial begin
    int t, n, base;
    bit ok;

    reset      = 1'b1;
    read       = 1'b0;
    write      = 1'b0;
    address    = '0;
    burstcount = BW'(1);
    writedata  = '0;
    byteenable = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_int("rst_waitrequest", int'(waitrequest), 1);
    chk_int("rst_rdv", int'(readdatavalid), 0);
    chk("rst_readdata", readdata, '0);
    chk_int("rst_err", int'(protocol_error), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk_int("idle_waitrequest", int'(waitrequest), 0);
    @(posedge clk);
    #1;

    tbl[0]  = '{1'b0, 5,    1, BE_ALL, {64{8'hA5}}, '0};
    tbl[1]  = '{1'b1, 5,    1, BE_ALL, '0, {64{8'hA5}}};
    tbl[2]  = '{1'b0, 16,   4, BE_ALL, '0, '0};
    tbl[3]  = '{1'b1, 16,   4, BE_ALL, '0, '0};
    tbl[4]  = '{1'b0, 16,   1, 64'h0,  {64{8'h55}}, '0};
    tbl[5]  = '{1'b1, 16,   1, BE_ALL, '0, '0};
    tbl[6]  = '{1'b0, 8,    1, BE_ALL, {64{8'hFF}}, '0};
    tbl[7]  = '{1'b0, 8,    1, 64'hF,  '0, '0};
    tbl[8]  = '{1'b1, 8,    1, BE_ALL, '0, {{480{1'b1}}, 32'h0}};
    tbl[9]  = '{1'b0, 1023, 3, BE_ALL, DW'(7), '0};
    tbl[10] = '{1'b1, 1023, 1, BE_ALL, '0, DW'(7)};
    tbl[11] = '{1'b1, 0,    1, BE_ALL, '0, DW'(8)};
    tbl[12] = '{1'b1, 1,    1, BE_ALL, '0, DW'(9)};

    for (int v = 0; v < 13; v++) begin
      if (tbl[v].is_rd) begin
        do_read($sformatf("tbl%0d", v), tbl[v].addr, tbl[v].bc, 1'b1, tbl[v].exp);
      end else begin
        for (int i = 0; i < tbl[v].bc; i++) wbuf[i] = tbl[v].data + DW'(i);
        do_write(tbl[v].addr, tbl[v].bc, tbl[v].be, -1);
      end
    end

    // read and write together in IDLE: write wins, read dropped, error sticky
    rq_data.delete();
    wbuf[0] = DW'(32'h1234);
    do_write(40, 1, BE_ALL, 0);
    repeat (12) @(negedge clk);
    @(posedge clk);
    chk_int("rw_no_rdv", rq_data.size(), 0);
    chk_int("rw_err", int'(protocol_error), 1);
    #1;
    do_read("rw_rd", 40, 1, 1'b0, '0);
    chk_int("rw_err_sticky", int'(protocol_error), 1);

    // reset clears the flag; burstcount 0 read returns one beat and flags
    do_reset(2);
    @(negedge clk);
    chk_int("rst_err_clear", int'(protocol_error), 0);
    @(posedge clk);
    #1;
    do_read("bc0", 40, 0, 1'b0, '0);
    chk_int("bc0_err", int'(protocol_error), 1);

    // read during a write burst is ignored but flagged
    do_reset(2);
    wbuf[0] = rnd512();
    wbuf[1] = rnd512();
    rq_data.delete();
    do_write(60, 2, BE_ALL, 1);
    repeat (10) @(negedge clk);
    @(posedge clk);
    chk_int("wrb_err", int'(protocol_error), 1);
    chk_int("wrb_no_rdv", rq_data.size(), 0);
    #1;
    do_read("wrb_rd", 60, 2, 1'b0, '0);

    // reset during the second beat of a burst-8 read
    rq_data.delete();
    address    = AW'(16);
    burstcount = BW'(8);
    read       = 1'b1;
    wait_accept(ok, t);
    read = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    chk_int("rst_mid_wait", int'(waitrequest), 1);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (10) @(negedge clk);
    @(posedge clk);
    chk_int("rst_mid_rdv", rq_data.size(), 0);
    #1;
    do_read("rst_mid_rd", 16, 4, 1'b0, '0);

    // randomized traffic inside a window that straddles the wrap point
    for (int i = 0; i < 52; i++) wbuf[i] = rnd512();
    do_write(1000, 52, BE_ALL, -1);
    for (int op = 0; op < 30; op++) begin
      n    = 1 + $urandom_range(0, 7);
      base = 1000 + $urandom_range(0, 39);
      if ($urandom_range(0, 1) == 1) begin
        for (int i = 0; i < n; i++) wbuf[i] = rnd512();
        do_write(base + 1024 * $urandom_range(0, 7), n, {$urandom, $urandom}, -1);
      end else begin
        do_read($sformatf("rnd%0d", op), base, n, 1'b0, '0);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
